lockin_demodulador: RTL



---
 rtl/lockin_pkg.sv | 17 +
 rtl/lockin_demodulador_if.sv | 26 ++
 rtl/lockin_ref_rom.sv | 64 ++++++
 rtl/lockin_demodulador.sv | 138 +++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared defaults and elaboration-time sizing helper for the lock-in demodulator
package lockin_pkg;

    localparam int Q_IN_DEF  = 24;
    localparam int Q_REF_DEF = 16;
    localparam int N_DEF     = 8;
    localparam int M_DEF     = 16;
    localparam int Q_OUT_DEF = 64;

    // Minimum accumulator width; an illegal N yields an impossible width so the check trips.
    function automatic int acc_width(int q_in, int q_ref, int m, int n);
        if (n < 4 || (n % 4) != 0)
            return 1 << 30;
        return q_in + q_ref + $clog2(m * n);
    endfunction

endpackage

// File: rtl/lockin_demodulador_if.sv
// rtl/lockin_demodulador_if.sv - sample input / demodulated result bundle
interface lockin_demodulador_if
    import lockin_pkg::*;
#(
    parameter int Q_in  = Q_IN_DEF,
    parameter int Q_out = Q_OUT_DEF
) ();

    logic                    clear;
    logic signed [Q_in-1:0]  data_in;
    logic                    data_in_valid;
    logic signed [Q_out-1:0] data_out_fase;
    logic signed [Q_out-1:0] data_out_cuad;
    logic                    data_out_valid;

    modport master (
        output clear, data_in, data_in_valid,
        input  data_out_fase, data_out_cuad, data_out_valid
    );

    modport slave (
        input  clear, data_in, data_in_valid,
        output data_out_fase, data_out_cuad, data_out_valid
    );

endinterface

// File: rtl/lockin_ref_rom.sv
// rtl/lockin_ref_rom.sv - sine/cosine reference table, built at elaboration, registered read
module lockin_ref_rom
    import lockin_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int Q_ref = Q_REF_DEF,
    localparam int IW   = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [IW-1:0]           index,
    output logic signed [Q_ref-1:0] sin_val,
    output logic signed [Q_ref-1:0] cos_val
);

    localparam real PI = 3.14159265358979323846;

    function automatic real taylor_sin(real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k < 14; k++) begin
            term = -term * x * x / ((2.0 * k) * (2.0 * k + 1.0));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Angle folded into [-pi, pi] so the series converges quickly; rounding is half away from zero.
    function automatic int table_at(int idx);
        real ang;
        real v;
        ang = 2.0 * PI * idx / N;
        if (ang > PI)
            ang = ang - 2.0 * PI;
        v = ((2.0 ** (Q_ref - 1)) - 1.0) * taylor_sin(ang);
        if (v >= 0.0)
            return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    logic signed [Q_ref-1:0] sin_tbl [N];
    logic signed [Q_ref-1:0] cos_tbl [N];

    for (genvar i = 0; i < N; i++) begin : g_tbl
        localparam int SIN_V = table_at(i);
        localparam int COS_V = table_at((i + N / 4) % N);
        assign sin_tbl[i] = Q_ref'(SIN_V);
        assign cos_tbl[i] = Q_ref'(COS_V);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sin_val <= '0;
            cos_val <= '0;
        end else if (en) begin
            sin_val <= sin_tbl[index];
            cos_val <= cos_tbl[index];
        end
    end

endmodule

// File: rtl/lockin_demodulador.sv
// rtl/lockin_demodulador.sv - dual-phase lock-in demodulator, one result pair per M*N samples
module lockin_demodulador
    import lockin_pkg::*;
#(
    parameter int Q_in  = Q_IN_DEF,
    parameter int Q_ref = Q_REF_DEF,
    parameter int N     = N_DEF,
    parameter int M     = M_DEF,
    parameter int Q_out = Q_OUT_DEF
) (
    input logic                  clk,
    input logic                  reset,
    lockin_demodulador_if.slave  bus
);

    localparam int NW = $clog2(N);
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = Q_in + Q_ref;

    if (Q_out < acc_width(Q_in, Q_ref, M, N)) begin : g_bad_cfg
        $error("lockin_demodulador: Q_out too narrow for M*N window, or N not a multiple of 4 >= 4");
    end

    logic [NW-1:0] n;
    logic [MW-1:0] m;
    logic          accept;
    logic          wrap_n;
    logic          wrap_m;

    logic                   v0, first0, last0;
    logic signed [Q_in-1:0] x0;
    logic [NW-1:0]          idx0;

    logic                    v1, first1, last1;
    logic signed [Q_in-1:0]  x1;
    logic signed [Q_ref-1:0] sin1, cos1;

    logic                 v2, first2, last2;
    logic signed [PW-1:0] p_s, p_c;

    logic signed [Q_out-1:0] acc_f, acc_c;
    logic signed [Q_out-1:0] sum_f, sum_c;

    assign accept = bus.data_in_valid & ~bus.clear;
    assign wrap_n = (n == NW'(N - 1));
    assign wrap_m = (m == MW'(M - 1));

    lockin_ref_rom #(.N(N), .Q_ref(Q_ref)) u_rom (
        .clk     (clk),
        .reset   (reset),
        .en      (v0),
        .index   (idx0),
        .sin_val (sin1),
        .cos_val (cos1)
    );

    // First product of a window replaces the accumulator, so no separate flush cycle is needed.
    always_comb begin
        sum_f = first2 ? Q_out'(p_s) : acc_f + Q_out'(p_s);
        sum_c = first2 ? Q_out'(p_c) : acc_c + Q_out'(p_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n              <= '0;
            m              <= '0;
            v0             <= 1'b0;
            first0         <= 1'b0;
            last0          <= 1'b0;
            x0             <= '0;
            idx0           <= '0;
            v1             <= 1'b0;
            first1         <= 1'b0;
            last1          <= 1'b0;
            x1             <= '0;
            v2             <= 1'b0;
            first2         <= 1'b0;
            last2          <= 1'b0;
            p_s            <= '0;
            p_c            <= '0;
            acc_f          <= '0;
            acc_c          <= '0;
            bus.data_out_fase  <= '0;
            bus.data_out_cuad  <= '0;
            bus.data_out_valid <= 1'b0;
        end else if (bus.clear) begin
            n              <= '0;
            m              <= '0;
            v0             <= 1'b0;
            v1             <= 1'b0;
            v2             <= 1'b0;
            acc_f          <= '0;
            acc_c          <= '0;
            bus.data_out_valid <= 1'b0;
        end else begin
            v0 <= accept;
            if (accept) begin
                x0     <= bus.data_in;
                idx0   <= n;
                first0 <= (n == '0) && (m == '0);
                last0  <= wrap_n && wrap_m;
                n      <= wrap_n ? '0 : n + NW'(1);
                if (wrap_n)
                    m <= wrap_m ? '0 : m + MW'(1);
            end

            v1 <= v0;
            if (v0) begin
                x1     <= x0;
                first1 <= first0;
                last1  <= last0;
            end

            v2 <= v1;
            if (v1) begin
                p_s    <= PW'(x1) * PW'(sin1);
                p_c    <= PW'(x1) * PW'(cos1);
                first2 <= first1;
                last2  <= last1;
            end

            bus.data_out_valid <= 1'b0;
            if (v2) begin
                if (last2) begin
                    bus.data_out_fase  <= sum_f;
                    bus.data_out_cuad  <= sum_c;
                    bus.data_out_valid <= 1'b1;
                    acc_f              <= '0;
                    acc_c              <= '0;
                end else begin
                    acc_f <= sum_f;
                    acc_c <= sum_c;
                end
            end
        end
    end

endmodule
